// File: rtl/uart_word_rx_if.sv
// Purpose : bundles the serial line, rate select and receive results of uart_word_rx.
// Latency : n/a (signal bundle only).
// Backpressure: none; consumers must take Rx_Done / word_valid pulses when they occur.
//
// Signals:
//   Rs232_Rx   serial line, idles high (driven by the board / bench)
//   baud_set   rate select, 0=9600 1=19200 2=38400 3=57600 4..7=115200
//   data_byte  last good byte; Rx_Done pulses when it updates
//   word       last assembled word, MSB byte first; word_valid pulses when it updates
//   frame_err  pulse on a bad stop bit
//   uart_state high while a frame is being received
interface uart_word_rx_if;
    logic        Rs232_Rx;
    logic [2:0]  baud_set;
    logic [7:0]  data_byte;
    logic        Rx_Done;
    logic [31:0] word;
    logic        word_valid;
    logic        frame_err;
    logic        uart_state;

    // master: the side that owns the serial pin and consumes the results
    modport master (
        output Rs232_Rx, baud_set,
        input  data_byte, Rx_Done, word, word_valid, frame_err, uart_state
    );

    // slave: the receiver itself
    modport slave (
        input  Rs232_Rx, baud_set,
        output data_byte, Rx_Done, word, word_valid, frame_err, uart_state
    );
endinterface

// File: rtl/uart_word_rx.sv
// Purpose : 8N1 UART receiver, 16x oversampled with 2-of-3 majority, packs 4 bytes into a word.
// Latency : Rx_Done one cycle after the stop-bit mid sample; word_valid one cycle after Rx_Done.
// Backpressure: none; results are single-cycle pulses with held data registers.
//
// Ports:
//   Clk    system clock (divider table is built for 50 MHz)
//   Rst_n  asynchronous active-low reset
//   rx_if  uart_word_rx_if.slave: Rs232_Rx/baud_set in; data_byte, Rx_Done,
//          word, word_valid, frame_err, uart_state out
module uart_word_rx #(
    parameter int CLK_FREQ     = 50_000_000,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic          Clk,
    input  logic          Rst_n,
    uart_word_rx_if.slave rx_if
);

    // CLK_FREQ only documents the clock the fixed divider table assumes.
    if (CLK_FREQ != 50_000_000) begin : g_divider_table_assumes_50mhz
    end

    localparam int TO_TICKS = TIMEOUT_BITS * 16;
    localparam int TO_W     = $clog2(TO_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    // Divider reload value per rate; the period is DIV+1 clocks per tick.
    function automatic logic [8:0] div_max(input logic [2:0] sel);
        logic [8:0] v;
        case (sel)
            3'd0:    v = 9'd324;
            3'd1:    v = 9'd161;
            3'd2:    v = 9'd80;
            3'd3:    v = 9'd53;
            default: v = 9'd26;
        endcase
        return v;
    endfunction

    // Synchroniser and edge-detect history
    logic            rx_meta_q, rx_sync_q, rx_prev_q;

    state_t          state_q, state_d;
    logic [2:0]      baud_q, baud_d;
    logic [8:0]      div_q, div_d;
    logic [3:0]      tick_cnt_q, tick_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [1:0]      smp_q, smp_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_byte_q, data_byte_d;
    logic            rx_done_q, rx_done_d;
    logic [31:0]     wsr_q, wsr_d;
    logic [1:0]      byte_cnt_q, byte_cnt_d;
    logic            word_pend_q, word_pend_d;
    logic [31:0]     word_q, word_d;
    logic            word_valid_q, word_valid_d;
    logic            frame_err_q, frame_err_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic tick;
    logic start_edge;
    logic maj;

    assign tick       = (div_q == div_max(baud_q));
    assign start_edge = (state_q == S_IDLE) && rx_prev_q && !rx_sync_q;
    // Only meaningful on the tick-9 sample: samples from ticks 7 and 8 plus the current line.
    assign maj        = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_sync_q) | (smp_q[1] & rx_sync_q);

    // The synchroniser resets to the idle-high line level so reset release
    // never looks like a start edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_if.Rs232_Rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= S_IDLE;
            baud_q       <= 3'd0;
            div_q        <= 9'd0;
            tick_cnt_q   <= 4'd0;
            bit_idx_q    <= 3'd0;
            smp_q        <= 2'b00;
            shift_q      <= 8'h00;
            data_byte_q  <= 8'h00;
            rx_done_q    <= 1'b0;
            wsr_q        <= 32'h0;
            byte_cnt_q   <= 2'd0;
            word_pend_q  <= 1'b0;
            word_q       <= 32'h0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            to_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            baud_q       <= baud_d;
            div_q        <= div_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_idx_q    <= bit_idx_d;
            smp_q        <= smp_d;
            shift_q      <= shift_d;
            data_byte_q  <= data_byte_d;
            rx_done_q    <= rx_done_d;
            wsr_q        <= wsr_d;
            byte_cnt_q   <= byte_cnt_d;
            word_pend_q  <= word_pend_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_err_d;
            to_cnt_q     <= to_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        baud_d       = baud_q;
        div_d        = tick ? 9'd0 : div_q + 9'd1;
        tick_cnt_d   = tick_cnt_q;
        bit_idx_d    = bit_idx_q;
        smp_d        = smp_q;
        shift_d      = shift_q;
        data_byte_d  = data_byte_q;
        rx_done_d    = 1'b0;
        wsr_d        = wsr_q;
        byte_cnt_d   = byte_cnt_q;
        word_pend_d  = 1'b0;
        word_d       = word_q;
        word_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        to_cnt_d     = to_cnt_q;

        // The 4th byte lands in wsr_q on the Rx_Done cycle; publish it one cycle later.
        if (word_pend_q) begin
            word_d       = wsr_q;
            word_valid_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    // Rate is latched here; baud_set is ignored for the rest of the frame.
                    state_d    = S_START;
                    baud_d     = rx_if.baud_set;
                    div_d      = 9'd0;
                    tick_cnt_d = 4'd0;
                    to_cnt_d   = '0;
                end else if (byte_cnt_q != 2'd0 && tick) begin
                    // Silent discard of a partial word left idle too long.
                    if (to_cnt_q == TO_W'(TO_TICKS - 1)) begin
                        to_cnt_d   = '0;
                        byte_cnt_d = 2'd0;
                        wsr_d      = 32'h0;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_W'(1);
                    end
                end
            end

            default: begin
                if (tick) begin
                    tick_cnt_d = tick_cnt_q + 4'd1;

                    if (tick_cnt_q == 4'd7) smp_d[0] = rx_sync_q;
                    if (tick_cnt_q == 4'd8) smp_d[1] = rx_sync_q;

                    if (tick_cnt_q == 4'd9) begin
                        case (state_q)
                            S_START: begin
                                if (maj) state_d = S_IDLE;  // false start
                            end
                            S_DATA: begin
                                shift_d = {maj, shift_q[7:1]};  // LSB arrives first
                            end
                            S_STOP: begin
                                // Rest of the stop bit is not watched, so a
                                // back-to-back start edge is never missed.
                                state_d = S_IDLE;
                                if (maj) begin
                                    data_byte_d = shift_q;
                                    rx_done_d   = 1'b1;
                                    wsr_d       = {wsr_q[23:0], shift_q};
                                    if (byte_cnt_q == 2'd3) begin
                                        byte_cnt_d  = 2'd0;
                                        word_pend_d = 1'b1;
                                    end else begin
                                        byte_cnt_d = byte_cnt_q + 2'd1;
                                    end
                                end else begin
                                    frame_err_d = 1'b1;
                                    byte_cnt_d  = 2'd0;
                                    wsr_d       = 32'h0;
                                end
                            end
                            default: ;
                        endcase
                    end

                    if (tick_cnt_q == 4'd15) begin
                        case (state_q)
                            S_START: begin
                                state_d   = S_DATA;
                                bit_idx_d = 3'd0;
                            end
                            S_DATA: begin
                                if (bit_idx_q == 3'd7) state_d = S_STOP;
                                else                   bit_idx_d = bit_idx_q + 3'd1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase
    end

    assign rx_if.data_byte  = data_byte_q;
    assign rx_if.Rx_Done    = rx_done_q;
    assign rx_if.word       = word_q;
    assign rx_if.word_valid = word_valid_q;
    assign rx_if.frame_err  = frame_err_q;
    assign rx_if.uart_state = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_word_rx.sv
// Purpose : self-checking bench for uart_word_rx against a frame-level model of the receive rules.
// Latency : n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_uart_word_rx;

    localparam int TIMEOUT_BITS = 20;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;

    uart_word_rx_if bus();

    uart_word_rx #(
        .CLK_FREQ    (50_000_000),
        .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .Clk  (Clk),
        .Rst_n(Rst_n),
        .rx_if(bus)
    );

    always #10 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: what the receiver must report, derived from the frames sent.
    logic [7:0]  exp_bytes[$];
    logic [31:0] exp_words[$];
    int          exp_ferr = 0;
    logic [7:0]  part[$];
    logic [7:0]  last_byte = 8'h00;
    logic [31:0] last_word = 32'h0;

    int  rx_count = 0;
    int  wv_count = 0;
    int  fe_count = 0;
    logic prev_rx_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // A frame with a good stop bit yields a byte; 4 good bytes in a row yield a word, first byte in the MSBs.
    function automatic void model_frame(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) begin
            exp_bytes.push_back(b);
            part.push_back(b);
            if (part.size() == 4) begin
                exp_words.push_back({part[0], part[1], part[2], part[3]});
                part.delete();
            end
        end else begin
            exp_ferr++;
            part.delete();
        end
    endfunction

    function automatic void model_idle(input int bits);
        if (bits >= TIMEOUT_BITS) part.delete();
    endfunction

    function automatic void model_reset();
        exp_bytes.delete();
        exp_words.delete();
        part.delete();
        exp_ferr  = 0;
        last_byte = 8'h00;
        last_word = 32'h0;
    endfunction

    // Compare process: every cycle, sampled on the falling edge.
    always @(negedge Clk) begin
        if (!Rst_n) begin
            check("reset data_byte",  {24'h0, bus.data_byte}, 32'h0);
            check("reset Rx_Done",    {31'h0, bus.Rx_Done}, 32'h0);
            check("reset word",       bus.word, 32'h0);
            check("reset word_valid", {31'h0, bus.word_valid}, 32'h0);
            check("reset frame_err",  {31'h0, bus.frame_err}, 32'h0);
            check("reset uart_state", {31'h0, bus.uart_state}, 32'h0);
            prev_rx_done = 1'b0;
        end else begin
            if (bus.Rx_Done) begin
                rx_count++;
                n_cmp++;
                if (exp_bytes.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected Rx_Done: data_byte %h, no byte expected", bus.data_byte);
                end else begin
                    last_byte = exp_bytes.pop_front();
                end
            end
            check("data_byte", {24'h0, bus.data_byte}, {24'h0, last_byte});

            if (bus.word_valid) begin
                wv_count++;
                n_cmp++;
                if (exp_words.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected word_valid: word %h, no word expected", bus.word);
                end else begin
                    last_word = exp_words.pop_front();
                end
                check("word_valid follows Rx_Done", {31'h0, prev_rx_done}, 32'h1);
            end
            check("word", bus.word, last_word);

            if (bus.frame_err) begin
                fe_count++;
                n_cmp++;
                if (exp_ferr == 0) begin
                    n_bad++;
                    $display("FAIL unexpected frame_err: got 1, required 0");
                end else begin
                    exp_ferr--;
                end
            end

            check("Rx_Done with word_valid", {31'h0, bus.Rx_Done & bus.word_valid}, 32'h0);
            check("Rx_Done with frame_err",  {31'h0, bus.Rx_Done & bus.frame_err}, 32'h0);
            prev_rx_done = bus.Rx_Done;
        end
    end

    function automatic int bit_clks(input logic [2:0] b);
        case (b)
            3'd0:    return 5208;  // true 9600 baud, slightly slower than the divider
            3'd1:    return 2604;
            3'd2:    return 1302;
            3'd3:    return 868;
            default: return 432;
        endcase
    endfunction

    task automatic drive_bit(input logic v, input int n);
        bus.Rs232_Rx = v;
        repeat (n) @(negedge Clk);
    endtask

    task automatic send(input logic [7:0] b, input logic stop, input logic [2:0] baud);
        int n;
        n = bit_clks(baud);
        model_frame(b, stop);
        bus.baud_set = baud;
        drive_bit(1'b0, n);
        bus.baud_set = 3'($urandom_range(0, 7));  // must be ignored mid-frame
        for (int i = 0; i < 8; i++) drive_bit(b[i], n);
        drive_bit(stop, n);
        drive_bit(1'b1, $urandom_range(4, 60));
    endtask

    function automatic logic [2:0] fast_baud();
        return 3'($urandom_range(4, 7));
    endfunction

    task automatic drain(input string name);
        for (int i = 0; i < 1000 && (exp_bytes.size() != 0 || exp_words.size() != 0 || exp_ferr != 0); i++)
            @(negedge Clk);
        check({name, " bytes outstanding"}, 32'(exp_bytes.size()), 32'h0);
        check({name, " words outstanding"}, 32'(exp_words.size()), 32'h0);
        check({name, " frame_err outstanding"}, 32'(exp_ferr), 32'h0);
    endtask

    initial begin
        repeat (400_000) @(posedge Clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0, f0;
        logic [7:0] pb;

        bus.Rs232_Rx = 1'b1;
        bus.baud_set = 3'd4;
        repeat (5) @(negedge Clk);
        #5 Rst_n = 1'b1;
        repeat (20) @(negedge Clk);

        // T1: four back-to-back bytes at 115200
        r0 = rx_count; w0 = wv_count;
        send(8'hAB, 1'b1, 3'd4);
        send(8'hCD, 1'b1, 3'd4);
        send(8'h12, 1'b1, 3'd4);
        send(8'h34, 1'b1, 3'd4);
        drain("T1");
        check("T1 word", bus.word, 32'hABCD1234);
        check("T1 data_byte", {24'h0, bus.data_byte}, 32'h34);
        check("T1 Rx_Done count", 32'(rx_count - r0), 32'd4);
        check("T1 word_valid count", 32'(wv_count - w0), 32'd1);

        // T2: first byte at 9600 (divider 324), rest at the fast rate
        send(8'h55, 1'b1, 3'd0);
        send(8'hA5, 1'b1, fast_baud());
        send(8'h5A, 1'b1, fast_baud());
        send(8'hFF, 1'b1, fast_baud());
        drain("T2");
        check("T2 word", bus.word, 32'h55A55AFF);

        // T3: 100-clock glitch is a false start
        r0 = rx_count; f0 = fe_count;
        bus.baud_set = 3'd4;
        drive_bit(1'b0, 50);
        check("glitch uart_state active", {31'h0, bus.uart_state}, 32'h1);
        drive_bit(1'b0, 50);
        drive_bit(1'b1, 332);
        check("glitch uart_state back to idle", {31'h0, bus.uart_state}, 32'h0);
        drive_bit(1'b1, 432);
        check("glitch Rx_Done count", 32'(rx_count - r0), 32'd0);
        check("glitch frame_err count", 32'(fe_count - f0), 32'd0);

        // T4: bad stop bit discards the partial word
        f0 = fe_count; w0 = wv_count;
        send(8'h11, 1'b1, fast_baud());
        send(8'h22, 1'b1, fast_baud());
        send(8'h33, 1'b0, fast_baud());
        send(8'h01, 1'b1, fast_baud());
        send(8'h02, 1'b1, fast_baud());
        send(8'h03, 1'b1, fast_baud());
        send(8'h04, 1'b1, fast_baud());
        drain("T4");
        check("T4 frame_err count", 32'(fe_count - f0), 32'd1);
        check("T4 word_valid count", 32'(wv_count - w0), 32'd1);
        check("T4 word", bus.word, 32'h01020304);
        check("T4 data_byte", {24'h0, bus.data_byte}, 32'h04);

        // T5: inter-byte timeout drops a lone byte
        w0 = wv_count;
        send(8'h11, 1'b1, 3'd4);
        model_idle(25);
        drive_bit(1'b1, 25 * 432);
        send(8'hDE, 1'b1, fast_baud());
        send(8'hAD, 1'b1, fast_baud());
        send(8'hBE, 1'b1, fast_baud());
        send(8'hEF, 1'b1, fast_baud());
        drain("T5");
        check("T5 word", bus.word, 32'hDEADBEEF);
        check("T5 word_valid count", 32'(wv_count - w0), 32'd1);

        // T6: reset during d4 of the second byte
        send(8'h77, 1'b1, 3'd4);
        drain("T6 pre");
        pb = 8'h88;
        bus.baud_set = 3'd4;
        drive_bit(1'b0, 432);
        for (int i = 0; i < 4; i++) drive_bit(pb[i], 432);
        drive_bit(pb[4], 216);
        check("T6 uart_state before reset", {31'h0, bus.uart_state}, 32'h1);
        #5 Rst_n = 1'b0;
        model_reset();
        bus.Rs232_Rx = 1'b1;
        repeat (20) @(negedge Clk);
        check("T6 in-reset data_byte", {24'h0, bus.data_byte}, 32'h0);
        check("T6 in-reset word", bus.word, 32'h0);
        #5 Rst_n = 1'b1;
        repeat (50) @(negedge Clk);
        w0 = wv_count;
        send(8'hCA, 1'b1, fast_baud());
        send(8'hFE, 1'b1, fast_baud());
        send(8'hBA, 1'b1, fast_baud());
        send(8'hBE, 1'b1, fast_baud());
        drain("T6");
        check("T6 word", bus.word, 32'hCAFEBABE);
        check("T6 word_valid count", 32'(wv_count - w0), 32'd1);
        check("final uart_state idle", {31'h0, bus.uart_state}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
